bias_accum_stage: RTL and testbench

- Consumer of the per-layer bias constant bus. It accumulates N_PASSES partial-sum beats from the adder trees, one per input-channel group, for N_adder_tree output lanes.
- After the last pass it adds the constant bias vector per lane, then saturates to 18 bits and optionally applies ReLU.
- It presents the result on a valid/ready output buffer.
- Sits between the adder-tree outputs and the activation/line-buffer writer of each layer.

---
 rtl/bias_accum_stage.sv | 159 +++++++++++++++
 tb/tb_bias_accum_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_accum_stage.sv
// bias_accum_stage
//
// Accumulates N_PASSES partial-sum beats per output vector across N_adder_tree independent
// lanes. It then adds the per-lane bias constant, saturates each lane to DATA_W bits, and can
// clamp negative lanes to zero. The result is held on a valid/ready output register until the
// downstream takes it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bias        constant bias bus, lane i at [DATA_W*(i+1)-1 : DATA_W*i]
//   psum_data   partial-sum beat, same lane packing
//   psum_valid  psum_data valid
//   psum_ready  stage accepts a psum beat this cycle
//   out_data    biased, saturated (optionally ReLU'd) result, same lane packing
//   out_valid   out_data valid
//   out_ready   downstream accepts out_data
//   pass_cnt    beats accepted for the vector in progress (debug)

module bias_accum_stage #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int ACC_W        = 24,
    parameter int N_PASSES     = 4,
    parameter int RELU_EN      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    input  logic [N_adder_tree*DATA_W-1:0] psum_data,
    input  logic                           psum_valid,
    output logic                           psum_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(N_PASSES):0]      pass_cnt
);

    localparam int CNT_W = $clog2(N_PASSES) + 1;

    // Output range of a DATA_W two's-complement lane, widened to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        StAccum,
        StBias,
        StSat,
        StHold
    } state_t;

    state_t                           r_state;
    logic                             r_psum_ready;
    logic                             r_out_valid;
    logic [N_adder_tree*DATA_W-1:0]   r_out_data;
    logic [CNT_W-1:0]                 r_pass_cnt;
    logic signed [ACC_W-1:0]          r_acc [N_adder_tree];

    logic                             w_accept;
    logic                             w_last_pass;
    logic signed [DATA_W-1:0]         w_psum_lane [N_adder_tree];
    logic signed [DATA_W-1:0]         w_bias_lane [N_adder_tree];
    logic signed [ACC_W-1:0]          w_psum_ext  [N_adder_tree];
    logic signed [ACC_W-1:0]          w_bias_ext  [N_adder_tree];
    logic signed [DATA_W-1:0]         w_sat       [N_adder_tree];
    logic [N_adder_tree*DATA_W-1:0]   w_result;

    assign w_accept    = psum_valid & r_psum_ready;
    assign w_last_pass = (r_pass_cnt == CNT_W'(N_PASSES - 1));

    // Lane unpacking, sign extension and saturation / ReLU of the current accumulator.
    always_comb begin
        w_result = '0;
        for (int l = 0; l < N_adder_tree; l++) begin
            w_psum_lane[l] = psum_data[l*DATA_W +: DATA_W];
            w_bias_lane[l] = bias[l*DATA_W +: DATA_W];
            w_psum_ext[l]  = ACC_W'(w_psum_lane[l]);
            w_bias_ext[l]  = ACC_W'(w_bias_lane[l]);

            if (r_acc[l] > SAT_MAX) begin
                w_sat[l] = SAT_MAX[DATA_W-1:0];
            end else if (r_acc[l] < SAT_MIN) begin
                w_sat[l] = SAT_MIN[DATA_W-1:0];
            end else begin
                w_sat[l] = r_acc[l][DATA_W-1:0];
            end

            if ((RELU_EN != 0) && w_sat[l][DATA_W-1]) begin
                w_result[l*DATA_W +: DATA_W] = '0;
            end else begin
                w_result[l*DATA_W +: DATA_W] = w_sat[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StAccum;
            r_psum_ready <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_pass_cnt   <= '0;
            for (int l = 0; l < N_adder_tree; l++) begin
                r_acc[l] <= '0;
            end
        end else begin
            case (r_state)
                StAccum: begin
                    r_psum_ready <= 1'b1;
                    if (w_accept) begin
                        for (int l = 0; l < N_adder_tree; l++) begin
                            // First beat overwrites, so no explicit clear between vectors.
                            if (r_pass_cnt == '0) begin
                                r_acc[l] <= w_psum_ext[l];
                            end else begin
                                r_acc[l] <= r_acc[l] + w_psum_ext[l];
                            end
                        end
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                        if (w_last_pass) begin
                            r_psum_ready <= 1'b0;
                            r_state      <= StBias;
                        end
                    end
                end
                StBias: begin
                    for (int l = 0; l < N_adder_tree; l++) begin
                        r_acc[l] <= r_acc[l] + w_bias_ext[l];
                    end
                    r_state <= StSat;
                end
                StSat: begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_pass_cnt  <= '0;
                    r_state     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_psum_ready <= 1'b1;
                        r_state      <= StAccum;
                    end
                end
                default: begin
                    r_state <= StAccum;
                end
            endcase
        end
    end

    assign psum_ready = r_psum_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign pass_cnt   = r_pass_cnt;

endmodule

// File: tb/tb_bias_accum_stage.sv
module tb_bias_accum_stage;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int NW = N * W;
    localparam longint VMAX = 131071;
    localparam longint VMIN = -131072;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] bias, psum_data;
    logic          psum_valid, out_ready;
    logic          psum_ready_a, psum_ready_b, out_valid_a, out_valid_b;
    logic [NW-1:0] out_data_a, out_data_b;
    logic [2:0]    pass_cnt_a, pass_cnt_b;

    logic [NW-1:0] bias_c, psum_c, out_data_c;
    logic          valid_c, ready_c, out_valid_c, out_ready_c;
    logic [0:0]    pass_cnt_c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bias_accum_stage #(.N_adder_tree(N), .DATA_W(W), .ACC_W(24), .N_PASSES(4), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bias(bias), .psum_data(psum_data), .psum_valid(psum_valid),
        .psum_ready(psum_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .pass_cnt(pass_cnt_a)
    );

    bias_accum_stage #(.N_adder_tree(N), .DATA_W(W), .ACC_W(24), .N_PASSES(4), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bias(bias), .psum_data(psum_data), .psum_valid(psum_valid),
        .psum_ready(psum_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .pass_cnt(pass_cnt_b)
    );

    bias_accum_stage #(.N_adder_tree(N), .DATA_W(W), .ACC_W(24), .N_PASSES(1), .RELU_EN(1)) dut_c (
        .clk(clk), .rst(rst), .bias(bias_c), .psum_data(psum_c), .psum_valid(valid_c),
        .psum_ready(ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .pass_cnt(pass_cnt_c)
    );

    task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        logic signed [W-1:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Reference: exact integer sum of n beats plus bias, then clamp, then optional ReLU.
    function automatic logic [NW-1:0] model(input logic [NW-1:0] beats [4], input int n,
                                            input logic [NW-1:0] b, input bit relu);
        logic [NW-1:0] r;
        r = '0;
        for (int l = 0; l < N; l++) begin
            longint s;
            s = sx(b[l*W +: W]);
            for (int k = 0; k < n; k++) s += sx(beats[k][l*W +: W]);
            if (s > VMAX) s = VMAX;
            if (s < VMIN) s = VMIN;
            if (relu && s < 0) s = 0;
            r[l*W +: W] = W'(s);
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] v;
        for (int l = 0; l < N; l++) v[l*W +: W] = W'($urandom);
        return v;
    endfunction

    // Offer one beat to A/B; returns at the negedge after the accepting edge, valid dropped.
    task automatic push_ab(input logic [NW-1:0] d);
        bit ok;
        ok = 1'b0;
        psum_data  = d;
        psum_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (psum_ready_a) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        psum_valid = 1'b0;
        chk("push_accepted", NW'(ok), NW'(1));
    endtask

    // Wait for a result on A/B, compare both against the model, then hand it off.
    task automatic take_ab(input string tag, input logic [NW-1:0] beats [4]);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid_a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid"}, NW'(seen), NW'(1));
        chk({tag, "_relu"}, out_data_a, model(beats, 4, bias, 1'b1));
        chk({tag, "_norelu"}, out_data_b, model(beats, 4, bias, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, NW'(out_valid_a), NW'(0));
        chk({tag, "_ready_back"}, NW'(psum_ready_a), NW'(1));
    endtask

    initial begin
        logic [NW-1:0] beats [4];
        logic [NW-1:0] held;
        logic [NW-1:0] exp_q [$];
        int last_out, n_out;

        rst = 1'b1; bias = '0; psum_data = '0; psum_valid = 1'b0; out_ready = 1'b0;
        bias_c = '0; psum_c = '0; valid_c = 1'b0; out_ready_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", NW'(psum_ready_a), NW'(0));
        chk("rst_valid", NW'(out_valid_a), NW'(0));
        chk("rst_data", out_data_a, NW'(0));
        chk("rst_cnt", NW'(pass_cnt_a), NW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", NW'(psum_ready_a), NW'(1));

        // Directed lanes 0..2 with random filler; latency and pass_cnt checks
        for (int k = 0; k < 4; k++) begin
            beats[k] = rand_vec();
            beats[k][0*W +: W] = 18'h00010;
            beats[k][1*W +: W] = 18'h1FFFF;
            beats[k][2*W +: W] = 18'h20000;
        end
        bias = rand_vec();
        bias[0*W +: W] = 18'h00868;
        bias[1*W +: W] = 18'h00100;
        bias[2*W +: W] = 18'h3DB60;
        for (int k = 0; k < 4; k++) begin
            push_ab(beats[k]);
            chk("cnt_inc", NW'(pass_cnt_a), NW'(k + 1));
        end
        chk("lat_t", NW'(out_valid_a), NW'(0));
        chk("lat_t_ready", NW'(psum_ready_a), NW'(0));
        @(negedge clk);
        chk("lat_t1", NW'(out_valid_a), NW'(0));
        @(negedge clk);
        chk("lat_t2", NW'(out_valid_a), NW'(1));
        chk("cnt_cleared", NW'(pass_cnt_a), NW'(0));
        chk("lane0", NW'(out_data_a[0*W +: W]), NW'(18'h008A8));
        chk("lane1_sat", NW'(out_data_a[1*W +: W]), NW'(18'h1FFFF));
        chk("lane2_relu", NW'(out_data_a[2*W +: W]), NW'(18'h00000));
        chk("lane2_norelu", NW'(out_data_b[2*W +: W]), NW'(18'h20000));
        chk("vec1_a", out_data_a, model(beats, 4, bias, 1'b1));
        chk("vec1_b", out_data_b, model(beats, 4, bias, 1'b0));

        // Backpressure with the next beat already offered
        held = out_data_a;
        for (int k = 0; k < 4; k++) beats[k] = rand_vec();
        psum_data  = beats[0];
        psum_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", NW'(psum_ready_a), NW'(0));
            chk("bp_valid", NW'(out_valid_a), NW'(1));
            chk("bp_stable", out_data_a, held);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", NW'(out_valid_a), NW'(0));
        for (int k = 0; k < 4; k++) push_ab(beats[k]);
        take_ab("bp_vec", beats);

        // Gapped valid: idle cycles must not count
        for (int k = 0; k < 4; k++) beats[k] = rand_vec();
        for (int k = 0; k < 4; k++) begin
            push_ab(beats[k]);
            chk("gap_cnt", NW'(pass_cnt_a), NW'(k + 1));
            if (k < 3) begin
                @(negedge clk);
                chk("gap_cnt_idle", NW'(pass_cnt_a), NW'(k + 1));
            end
        end
        take_ab("gap_vec", beats);

        // Reset mid-vector discards partial accumulation
        bias = '0;
        push_ab(rand_vec());
        push_ab(rand_vec());
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", NW'(psum_ready_a), NW'(0));
        chk("mid_rst_valid", NW'(out_valid_a), NW'(0));
        chk("mid_rst_data", out_data_a, NW'(0));
        chk("mid_rst_cnt", NW'(pass_cnt_a), NW'(0));
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < N; l++) beats[k][l*W +: W] = 18'h00001;
            push_ab(beats[k]);
        end
        take_ab("post_rst", beats);
        chk("post_rst_lane5", NW'(out_data_b[5*W +: W]), NW'(18'h00004));

        // Fully random vectors and biases
        for (int v = 0; v < 3; v++) begin
            bias = rand_vec();
            for (int k = 0; k < 4; k++) beats[k] = rand_vec();
            for (int k = 0; k < 4; k++) push_ab(beats[k]);
            take_ab("rand_vec", beats);
        end

        // N_PASSES = 1 streaming: one result every 4 cycles
        bias_c = rand_vec();
        psum_c = rand_vec();
        valid_c = 1'b1;
        out_ready_c = 1'b1;
        last_out = -1;
        n_out = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid_c) begin
                logic [NW-1:0] e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("np1_data", out_data_c, e);
                if (last_out >= 0) chk("np1_interval", NW'(cyc - last_out), NW'(4));
                last_out = cyc;
                n_out++;
            end
            if (ready_c) begin
                beats[0] = psum_c;
                exp_q.push_back(model(beats, 1, bias_c, 1'b1));
            end else begin
                psum_c = rand_vec();
            end
            @(negedge clk);
        end
        chk("np1_count", NW'(n_out >= 8), NW'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
